// File: rtl/time_counter.sv
// rtl/time_counter.sv - BCD hh:mm:ss time-of-day counter with prescaler and handshaked load
// Optional 12-hour mode with PM flag: define CLK_12H_MODE_EN.
module time_counter #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       set_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       sec_tick,
    output logic       set_err
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

`ifdef CLK_12H_MODE_EN
    localparam logic [7:0] HH_RST = 8'h12;
`else
    localparam logic [7:0] HH_RST = 8'h00;
`endif

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          tick;
    logic          load_ok;
    logic          ss_wrap;
    logic          mm_wrap;
    logic [7:0]    ss_nx;
    logic [7:0]    mm_nx;
    logic [7:0]    hh_nx;
    logic          pm_flip;

    function automatic logic digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign set_ready = (state == ST_IDLE);
    assign accept    = set_valid & set_ready;
    // A load accepted in the same cycle as a terminal count swallows that tick.
    assign tick      = run && (state == ST_IDLE) && (cnt == CNT_MAX) && !accept;

    always_comb begin
        load_ok = digits_ok(set_hh) && digits_ok(set_mm) && digits_ok(set_ss)
                  && (set_ss <= 8'h59) && (set_mm <= 8'h59);
`ifdef CLK_12H_MODE_EN
        load_ok = load_ok && (set_hh >= 8'h01) && (set_hh <= 8'h12);
`else
        load_ok = load_ok && (set_hh <= 8'h23);
`endif
    end

    // Full carry chain resolved combinationally so the display never shows a partial roll-over.
    always_comb begin
        ss_wrap = (ss == 8'h59);
        mm_wrap = (mm == 8'h59);
        ss_nx   = ss_wrap ? 8'h00 : bcd_inc(ss);
        mm_nx   = mm;
        hh_nx   = hh;
        pm_flip = 1'b0;
        if (ss_wrap) begin
            mm_nx = mm_wrap ? 8'h00 : bcd_inc(mm);
            if (mm_wrap) begin
`ifdef CLK_12H_MODE_EN
                if (hh == 8'h12) begin
                    hh_nx = 8'h01;
                end else if (hh == 8'h11) begin
                    hh_nx   = 8'h12;
                    pm_flip = 1'b1;
                end else begin
                    hh_nx = bcd_inc(hh);
                end
`else
                hh_nx = (hh == 8'h23) ? 8'h00 : bcd_inc(hh);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ss       <= 8'h00;
            mm       <= 8'h00;
            hh       <= HH_RST;
            sec_tick <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            sec_tick <= tick;
            set_err  <= accept & ~load_ok;
            if (accept) begin
                state <= ST_LOAD;
                if (load_ok) begin
                    ss  <= set_ss;
                    mm  <= set_mm;
                    hh  <= set_hh;
                    cnt <= '0;
                end
            end else begin
                state <= ST_IDLE;
                if ((state == ST_IDLE) && run)
                    cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                if (tick) begin
                    ss <= ss_nx;
                    mm <= mm_nx;
                    hh <= hh_nx;
                end
            end
        end
    end

`ifdef CLK_12H_MODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pm <= 1'b0;
        else if (accept && load_ok)
            pm <= set_pm;
        else if (tick && pm_flip)
            pm <= ~pm;
    end
`else
    logic unused_set_pm;
    assign unused_set_pm = set_pm ^ pm_flip;
    assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - randomized self-checking bench for time_counter against a seconds-of-day model
module tb_time_counter;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       set_valid;
    logic       set_ready;
    logic [7:0] set_hh, set_mm, set_ss;
    logic       set_pm;
    logic [7:0] hh, mm, ss;
    logic       pm;
    logic       sec_tick;
    logic       set_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time as seconds since midnight, prescaler as an integer.
    int t;
    int cnt;
    bit in_load;
    bit e_tick;
    bit e_err;

    time_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .set_valid(set_valid), .set_ready(set_ready),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
        .hh(hh), .mm(mm), .ss(ss), .pm(pm),
        .sec_tick(sec_tick), .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int decode(input logic [7:0] h, input logic [7:0] m,
                                  input logic [7:0] s, input logic p);
        int hv, mv, sv;
        if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9)
            return -1;
        hv = h[7:4] * 10 + h[3:0];
        mv = m[7:4] * 10 + m[3:0];
        sv = s[7:4] * 10 + s[3:0];
        if (sv > 59 || mv > 59) return -1;
`ifdef CLK_12H_MODE_EN
        if (hv < 1 || hv > 12) return -1;
        hv = (hv % 12) + (p ? 12 : 0);
`else
        if (hv > 23 || p === 1'bx) return -1;
`endif
        return hv * 3600 + mv * 60 + sv;
    endfunction

    task automatic model_reset();
        t = 0; cnt = 0; in_load = 0; e_tick = 0; e_err = 0;
    endtask

    task automatic compare_all();
        int h, hd;
        bit pe;
        h = t / 3600;
`ifdef CLK_12H_MODE_EN
        hd = (h % 12 == 0) ? 12 : h % 12;
        pe = (h >= 12);
`else
        hd = h;
        pe = 1'b0;
`endif
        chk("hh", hh, to_bcd(hd));
        chk("mm", mm, to_bcd((t / 60) % 60));
        chk("ss", ss, to_bcd(t % 60));
        chk("pm", pm, pe);
        chk("sec_tick", sec_tick, e_tick);
        chk("set_err", set_err, e_err);
        chk("set_ready", set_ready, !in_load);
    endtask

    // Drive one cycle of inputs (called just after a falling edge), advance the model, check after the edge.
    task automatic step(input logic r, input logic sv, input logic [7:0] h,
                        input logic [7:0] m, input logic [7:0] s, input logic p);
        int ld;
        run = r; set_valid = sv; set_hh = h; set_mm = m; set_ss = s; set_pm = p;
        if (sv && !in_load) begin
            in_load = 1; e_tick = 0;
            ld = decode(h, m, s, p);
            if (ld >= 0) begin
                t = ld; cnt = 0; e_err = 0;
            end else begin
                e_err = 1;
            end
        end else if (in_load) begin
            in_load = 0; e_tick = 0; e_err = 0;
        end else begin
            e_err = 0; e_tick = 0;
            if (r) begin
                if (cnt == TD - 1) begin
                    cnt = 0; t = (t + 1) % 86400; e_tick = 1;
                end else begin
                    cnt++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic load(input int hv, input int mv, input int sv, input logic p);
        step(1'b1, 1'b1, to_bcd(hv), to_bcd(mv), to_bcd(sv), p);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; set_valid = 1'b0;
        set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; set_pm = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Free run: three ticks in twelve cycles
        idle(12);

        // Full roll-over in one edge
`ifdef CLK_12H_MODE_EN
        load(11, 59, 59, 1'b0);
        idle(5);
        load(12, 59, 59, 1'b1);
        idle(5);
`else
        load(23, 59, 59, 1'b0);
        idle(5);
        load(9, 59, 59, 1'b0);
        idle(5);
`endif

        // Illegal seconds value
        step(1'b1, 1'b1, 8'h10, 8'h34, 8'h5A, 1'b0);
        idle(3);

        // Load on the prescaler's third count, then on the terminal count
        for (int i = 0; i < 8 && cnt != 2; i++) idle(1);
        load(5, 6, 7, 1'b0);
        idle(6);
        for (int i = 0; i < 8 && cnt != 3; i++) idle(1);
        load(10, 20, 30, 1'b1);
        idle(6);

        // Hold with run=0, load still accepted
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset in the LOAD cycle
        load(8, 30, 0, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Randomized traffic biased toward roll-over values
        for (int i = 0; i < 3000; i++) begin
            logic       r, v, p;
            logic [7:0] h, m, s;
            r = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 11) == 0);
            p = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
            end else begin
`ifdef CLK_12H_MODE_EN
                h = to_bcd($urandom_range(1, 12));
`else
                h = to_bcd($urandom_range(0, 23));
`endif
                m = to_bcd(($urandom_range(0, 1) == 0) ? 59 : $urandom_range(0, 59));
                s = to_bcd($urandom_range(50, 59));
            end
            step(r, v, h, m, s, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per one-second tick; legal range 2..2^27.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  1 = prescaler and time advance; 0 = hold.
REQ-005 set_valid  input  1  load request, held until accepted.
REQ-006 set_ready  output  1  load can be accepted this cycle.
REQ-007 set_hh, set_mm, set_ss  input  8 each  packed BCD load value (tens[7:4], units[3:0]).
REQ-008 set_pm  input  1  PM flag for load; used only when CLK_12H_MODE_EN is defined.
REQ-009 hh, mm, ss  output  8 each  current time, packed BCD, registered.
REQ-010 pm  output  1  PM indicator; constant 0 when CLK_12H_MODE_EN is not defined.
REQ-011 sec_tick  output  1  one-cycle pulse, high in the cycle after the outputs advanced by one second.
REQ-012 set_err  output  1  one-cycle pulse, load rejected.

Function
REQ-013 Prescaler counts 0..TICK_DIV-1 while run=1, holds while run=0; internal tick asserted when count=TICK_DIV-1 and run=1, count then wraps to 0.
REQ-014 On tick: ss BCD +1; ss 59->00 carries into mm; mm 59->00 carries into hh; 24h: hh 23->00.
REQ-015 Every carry resolves in the same cycle; outputs never show an intermediate value (e.g. 09:59:59 -> 10:00:00 in one edge).
REQ-016 States: IDLE (set_ready=1), LOAD (set_ready=0, exactly one cycle), then back to IDLE.
REQ-017 Accept = set_valid & set_ready; on the next edge state=LOAD; if value legal, hh/mm/ss(/pm) take the load value and the prescaler clears to 0.
REQ-018 Legal load: every BCD digit <=9, ss<=59, mm<=59, hh<=23 (24h) or 01..12 (12h); illegal load leaves time unchanged and pulses set_err in the LOAD cycle.
REQ-019 Tick coinciding with an accept: the load wins, the tick is discarded, and sec_tick is not pulsed.
REQ-020 Ticks in the LOAD cycle: the prescaler holds, so no tick can occur.
REQ-021 run=0 holds the time; loads are still accepted.
REQ-022 sec_tick is not asserted by a load.

Reset
REQ-023 rst_n=0 immediately forces: prescaler=0, state=IDLE, ss=mm=8'h00, hh=8'h00 (24h) or 8'h12 (12h), pm=0, sec_tick=0, set_err=0, set_ready=1.
REQ-024 Reset asserted during LOAD aborts the load; the post-reset time is the reset value.
REQ-025 Deassertion is synchronous to clk externally; the first tick occurs TICK_DIV cycles after the first run=1 edge.

Configuration
REQ-026 Macro CLK_12H_MODE_EN defined: 12h mode; hh range 01..12; 11:59:59 -> 12:00:00 toggles pm; 12:59:59 -> 01:00:00 leaves pm unchanged; set_pm is loaded.
REQ-027 Macro absent: 24h mode; pm tied to 0; set_pm ignored.

Verification (TICK_DIV=4)
REQ-028 Reset, run=1 for 12 cycles -> ss=00,01,02,03 with sec_tick pulsed 3 times, every 4th cycle.
REQ-029 Load 23:59:59 (24h), run=1 -> after 4 cycles hh:mm:ss=00:00:00 in one step, sec_tick=1.
REQ-030 Load ss=8'h5A -> set_err pulse, time unchanged, set_ready low one cycle then high.
REQ-031 set_valid asserted on the prescaler's 3rd count -> load value appears, no sec_tick, next tick 4 cycles after LOAD.
REQ-032 12h build: load 11:59:59 pm=0, tick -> 12:00:00 pm=1; load 12:59:59, tick -> 01:00:00 pm unchanged.
REQ-033 rst_n pulsed low mid-LOAD -> outputs at reset values asynchronously, set_ready=1 after release.
